// File: rtl/unsigned_calc_seq.sv
// Multi-cycle unsigned ADD/SUB/MUL calculator built around a one-bit full adder and shift registers.
// Define UNSIGNED_CALC_SAT_EN to make ADD/SUB saturate instead of wrapping.
module unsigned_calc_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [1:0]           i_op,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_result,
  output logic                 o_carry,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshake: i_start is a request sampled only outside RUN; o_busy marks
  // RUN; o_done is a one-cycle pulse during which o_result/o_carry are new.
  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     sum_q, sum_d;
  logic [1:0]           op_q, op_d;
  logic                 carry_q, carry_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 rcarry_q, rcarry_d;

  logic                 accept;
  logic                 last_step;
  logic                 fa_a, fa_b, fa_s, fa_co;
  logic [WIDTH-1:0]     sum_next;
  logic [2*WIDTH-1:0]   acc_next;

  assign accept    = (state_q != ST_RUN) && i_start;
  assign last_step = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      rcarry_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      rcarry_q <= rcarry_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = i_start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit-serial datapath: SUB reuses the adder as A + ~B + 1.
  always_comb begin
    fa_a     = a_q[0];
    fa_b     = b_q[0] ^ (op_q == OP_SUB);
    fa_s     = fa_a ^ fa_b ^ carry_q;
    fa_co    = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
    sum_next = {fa_s, sum_q[WIDTH-1:1]};
    acc_next = b_q[0] ? (acc_q + mcand_q) : acc_q;

    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    op_d     = op_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    rcarry_d = rcarry_q;

    if (accept) begin
      a_d     = i_a;
      b_d     = i_b;
      op_d    = i_op;
      cnt_d   = '0;
      carry_d = (i_op == OP_SUB);
      sum_d   = '0;
      acc_d   = '0;
      mcand_d = {{WIDTH{1'b0}}, i_a};
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      cnt_d   = cnt_q + CW'(1);
      carry_d = fa_co;
      sum_d   = sum_next;
      acc_d   = acc_next;
      mcand_d = mcand_q << 1;
    end

    if (last_step) begin
      case (op_q)
        OP_ADD: begin
          result_d = {{WIDTH{1'b0}}, sum_next};
          rcarry_d = fa_co;
`ifdef UNSIGNED_CALC_SAT_EN
          if (fa_co) result_d = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
`endif
        end
        OP_SUB: begin
          result_d = {{WIDTH{1'b0}}, sum_next};
          rcarry_d = ~fa_co;
`ifdef UNSIGNED_CALC_SAT_EN
          if (!fa_co) result_d = '0;
`endif
        end
        OP_MUL: begin
          result_d = acc_next;
          rcarry_d = 1'b0;
        end
        default: begin
          result_d = '0;
          rcarry_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_busy      = (state_q == ST_RUN);
    o_done      = (state_q == ST_DONE);
    o_result    = result_q;
    o_carry     = rcarry_q;
    o_dbg_state = state_q;
  end

endmodule

// File: tb/tb_unsigned_calc_seq.sv
// Bench for unsigned_calc_seq: spec vectors, handshake corner cases, reset abort,
// randomized operations against an arithmetic model, and a WIDTH=4 instance.
module tb_unsigned_calc_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           i_rst, i_start;
  logic [1:0]     i_op;
  logic [W-1:0]   i_a, i_b;
  logic           o_busy, o_done, o_carry;
  logic [2*W-1:0] o_result;
  logic [1:0]     o_dbg_state;

  logic           s4_start;
  logic [1:0]     s4_op;
  logic [3:0]     s4_a, s4_b;
  logic           s4_busy, s4_done, s4_carry;
  logic [7:0]     s4_result;
  logic [1:0]     s4_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] last_res;
  logic           last_c;

  always #5 clk = ~clk;

  unsigned_calc_seq #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_op(i_op), .i_a(i_a), .i_b(i_b),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result), .o_carry(o_carry),
    .o_dbg_state(o_dbg_state)
  );

  unsigned_calc_seq #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_start(s4_start), .i_op(s4_op), .i_a(s4_a), .i_b(s4_b),
    .o_busy(s4_busy), .o_done(s4_done), .o_result(s4_result), .o_carry(s4_carry),
    .o_dbg_state(s4_dbg_state)
  );

  typedef struct {
    logic [1:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_res;
    logic           exp_c;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic for a w-bit calculator.
  function automatic void model(input int w, input logic [1:0] op, input int unsigned a,
                                input int unsigned b, output logic [2*W-1:0] r, output logic c);
    int unsigned m, s;
    m = 1 << w;
    r = '0;
    c = 1'b0;
    case (op)
      2'b00: begin
        s = a + b;
        c = (s >= m);
        r = (2*W)'(s % m);
`ifdef UNSIGNED_CALC_SAT_EN
        if (c) r = (2*W)'(m - 1);
`endif
      end
      2'b01: begin
        c = (a < b);
        r = c ? (2*W)'(a + m - b) : (2*W)'(a - b);
`ifdef UNSIGNED_CALC_SAT_EN
        if (c) r = '0;
`endif
      end
      2'b10: r = (2*W)'(a * b);
      default: ;
    endcase
  endfunction

  // Issue one operation starting at the next falling edge; if pulse_at > 0,
  // pulse i_start (with junk operands) so it is sampled at E0+pulse_at+1.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] exp_res, input logic exp_c, input int pulse_at);
    int lat;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_a = W'($urandom); i_b = W'($urandom); i_op = 2'($urandom);
    check("busy_after_start", 32'(o_busy), 32'd1);
    lat = 0;
    while (!o_done && lat < W + 4) begin
      @(posedge clk); #1;
      lat++;
      i_start = (pulse_at > 0) && (lat == pulse_at);
      if (i_start) begin
        i_a = W'($urandom); i_b = W'($urandom);
      end
      if (lat == W - 1) begin
        check("hold_result", 32'(o_result), 32'(last_res));
        check("hold_carry", 32'(o_carry), 32'(last_c));
        check("busy_mid", 32'(o_busy), 32'd1);
      end
    end
    i_start = 1'b0;
    check("latency", 32'(lat), 32'(W));
    check("busy_at_done", 32'(o_busy), 32'd0);
    check("result", 32'(o_result), 32'(exp_res));
    check("carry", 32'(o_carry), 32'(exp_c));
    last_res = exp_res;
    last_c   = exp_c;
  endtask

  task automatic run4(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp_res, input logic exp_c);
    int lat;
    @(negedge clk);
    s4_start = 1'b1; s4_op = op; s4_a = a; s4_b = b;
    @(posedge clk); #1;
    s4_start = 1'b0; s4_a = 4'($urandom); s4_b = 4'($urandom);
    lat = 0;
    while (!s4_done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w4_latency", 32'(lat), 32'd4);
    check("w4_result", 32'(s4_result), 32'(exp_res));
    check("w4_carry", 32'(s4_carry), 32'(exp_c));
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    logic [2*W-1:0] mr;
    logic           mc;
    logic [W-1:0]   ra, rb;
    logic [1:0]     rop;
    int             seen_done;
    logic [7:0]     r4;
    logic           c4;

    i_rst = 1'b1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    s4_start = 1'b0; s4_op = '0; s4_a = '0; s4_b = '0;
    last_res = '0; last_c = 1'b0;

`ifdef UNSIGNED_CALC_SAT_EN
    vecs.push_back('{2'b00, 8'd200, 8'd100, 16'h00FF, 1'b1});
    vecs.push_back('{2'b01, 8'd5,   8'd7,   16'h0000, 1'b1});
`else
    vecs.push_back('{2'b00, 8'd200, 8'd100, 16'h002C, 1'b1});
    vecs.push_back('{2'b01, 8'd5,   8'd7,   16'h00FE, 1'b1});
`endif
    vecs.push_back('{2'b01, 8'd7,   8'd5,   16'h0002, 1'b0});
    vecs.push_back('{2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0});
    vecs.push_back('{2'b10, 8'd0,   8'd200, 16'h0000, 1'b0});
    vecs.push_back('{2'b00, 8'd1,   8'd1,   16'h0002, 1'b0});
    vecs.push_back('{2'b11, 8'd99,  8'd42,  16'h0000, 1'b0});
    vecs.push_back('{2'b00, 8'd255, 8'd0,   16'h00FF, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    check("rst_carry", 32'(o_carry), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    check("rst_w4_result", 32'(s4_result), 32'd0);
    @(negedge clk);
    i_rst = 1'b0;

    // Vectors issued back-to-back: each start lands in the previous DONE cycle.
    foreach (vecs[i]) begin
      v = vecs[i];
      do_op(v.op, v.a, v.b, v.exp_res, v.exp_c, 0);
    end

    // Start pulse sampled at E0+3 while running is ignored.
    do_op(2'b10, 8'd13, 8'd11, 16'd143, 1'b0, 2);
    @(posedge clk); #1;
    check("idle_after_done", 32'(o_dbg_state), 32'd0);
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("hold_after_done", 32'(o_result), 32'd143);

    // Reset at E0+4 of a MUL aborts it with no done pulse.
    @(negedge clk);
    i_start = 1'b1; i_op = 2'b10; i_a = 8'd255; i_b = 8'd255;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_result", 32'(o_result), 32'd0);
    check("abort_carry", 32'(o_carry), 32'd0);
    seen_done = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (o_done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    last_res = '0; last_c = 1'b0;

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    i_rst = 1'b1; i_start = 1'b1; i_op = 2'b00; i_a = 8'd3; i_b = 8'd4;
    @(posedge clk); #1;
    i_rst = 1'b0; i_start = 1'b0;
    check("rst_start_busy", 32'(o_busy), 32'd0);
    check("rst_start_state", 32'(o_dbg_state), 32'd0);

    // Randomized operations checked against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      if (n % 8 == 0) rb = ra;
      model(W, rop, ra, rb, mr, mc);
      do_op(rop, ra, rb, mr, mc, (n % 5 == 0) ? 4 : 0);
      if (n % 3 == 0) repeat (2) @(posedge clk);
    end

    // Width-generic instance.
    i_rst = 1'b0;
`ifdef UNSIGNED_CALC_SAT_EN
    run4(2'b00, 4'd15, 4'd1, 8'h0F, 1'b1);
`else
    run4(2'b00, 4'd15, 4'd1, 8'h00, 1'b1);
`endif
    run4(2'b10, 4'd15, 4'd15, 8'hE1, 1'b0);
    for (int n = 0; n < 6; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = W'($urandom_range(0, 15));
      rb  = W'($urandom_range(0, 15));
      model(4, rop, ra, rb, mr, mc);
      r4 = mr[7:0];
      c4 = mc;
      run4(rop, ra[3:0], rb[3:0], r4, c4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unsigned_calc_seq.md
# unsigned_calc_seq

Sequential, parametrised unsigned calculator that performs WIDTH-bit add, subtract or multiply over multiple clock cycles using a single-bit full-adder datapath plus shift registers. It is the clocked, width-generic successor to the combinational 1-bit adder cell in the combinational-circuits section. It sits between operand sources and a result consumer and uses a start/busy/done handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- i_clk  in  1  rising-edge clock.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  request a new operation; sampled only when the block is idle or done.
- i_op  in  2  operation: 2'b00 ADD, 2'b01 SUB, 2'b10 MUL, 2'b11 reserved.
- i_a  in  WIDTH  operand A, unsigned.
- i_b  in  WIDTH  operand B, unsigned.
- o_busy  out  1  operation in progress.
- o_done  out  1  one-cycle pulse; o_result and o_carry are valid.
- o_result  out  2*WIDTH  result; held until the next accepted start.
- o_carry  out  1  ADD carry-out, or SUB borrow (A<B); 0 for MUL and reserved.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE or DONE:** when i_start=1, latch i_a, i_b and i_op, clear the step counter, and go to RUN.
- **IDLE or DONE, no start:** DONE goes to IDLE; IDLE stays in IDLE.
- **RUN:** execute exactly one step per cycle for WIDTH steps. After the final step, go to DONE.
- **ADD:**
  - Start with carry register = 0.
  - Each step adds bit k of A, bit k of B and the carry through the full adder, and shifts the sum bit into the result.
  - Final: o_result = {WIDTH zeros, sum mod 2^WIDTH}; o_carry = final carry.
- **SUB:**
  - Compute A + ~B + 1: carry register starts at 1 and B is inverted per bit.
  - Final: low half = (A−B) mod 2^WIDTH, upper half = 0; o_carry = ~final carry, i.e. 1 iff A<B.
- **MUL:**
  - Shift-add. Each step, if bit k of B is 1, add the multiplicand (A shifted left k) into a 2*WIDTH accumulator.
  - Final: o_result = full product A*B; o_carry = 0. The product never overflows.
- **Reserved op (2'b11):** same WIDTH-cycle latency; o_result = 0, o_carry = 0.
- i_start while in RUN is ignored. Operands are not re-sampled during RUN.
- Input changes on i_a, i_b or i_op after the accepting edge have no effect.

## Timing
- **Reset values:** o_busy=0, o_done=0, o_result=0, o_carry=0; FSM in IDLE; internal registers cleared.
- Let E0 be the rising edge that samples i_start=1.
- o_busy is 1 from E0 until edge E0+WIDTH; it is 0 after E0+WIDTH.
- At edge E0+WIDTH, o_done goes to 1 and o_result/o_carry update. Start-to-done latency is WIDTH cycles.
- o_done is high for exactly one cycle (E0+WIDTH to E0+WIDTH+1).
- o_result and o_carry hold from E0+WIDTH until the next completion or reset. They do not change while the next operation runs.
- **Back-to-back:** i_start=1 during the DONE cycle is accepted. o_busy is then 1 in the following cycle with no idle gap, giving a throughput of one operation per WIDTH cycles.
- **Reset mid-operation:** at the reset edge, the FSM returns to IDLE and all outputs return to reset values. No o_done is produced for the aborted operation.
- **Reset and i_start in the same cycle:** reset wins and the start is dropped.

## Configuration
- **UNSIGNED_CALC_SAT_EN defined — saturating ADD/SUB:**
  - ADD with carry-out: low half = all ones, o_carry = 1.
  - SUB with borrow: low half = 0, o_carry = 1.
  - MUL, the reserved op and latency are unchanged.
- **Not defined:** modular (wrap-around) results exactly as described in Operation.

## Test plan
All scenarios use WIDTH=8 unless noted.
- **ADD:** i_op=00, A=200, B=100, start at E0 -> o_done at E0+8, o_result=16'h002C, o_carry=1. With UNSIGNED_CALC_SAT_EN: o_result=16'h00FF, o_carry=1.
- **SUB:** i_op=01, A=5, B=7 -> o_result=16'h00FE, o_carry=1. A=7, B=5 -> o_result=16'h0002, o_carry=0. With UNSIGNED_CALC_SAT_EN, A=5, B=7 -> o_result=16'h0000, o_carry=1.
- **MUL:** i_op=10, A=255, B=255 -> o_result=16'hFE01, o_carry=0. A=0, B=200 -> o_result=0.
- **Handshake:**
  - Pulse i_start at E0+3 during RUN -> ignored; o_done occurs only at E0+8.
  - i_start held during the DONE cycle with ADD 1+1 -> o_done 8 cycles later, o_result=16'h0002.
  - The previous result holds in between.
- **Reset mid-operation:** i_rst=1 at E0+4 of a MUL -> all outputs 0 next cycle; no o_done pulse follows.
- **Width generic:** WIDTH=4, ADD 15+1 -> o_done at E0+4, o_result=8'h00, o_carry=1. MUL 15*15 -> o_result=8'hE1.
